// File: rtl/course_shifter.sv
// Box-course shifter: holds LENGTH box directions, exposes next box + LOOK-wide lookahead, advances on correct key.
// Latency: registered outputs; q/window/remaining/pulses reflect a load or step one cycle after it is sampled.
// Backpressure: none; load/step are single-cycle pulses accepted every cycle. Optional COURSE_MISS_COUNT_EN adds miss_count.
module course_shifter #(
  parameter int LENGTH = 33,
  parameter int LOOK   = 4,
  parameter int CNT_W  = $clog2(LENGTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LENGTH-1:0] load_val,
  input  logic              mode_wrap,
  input  logic              step,
  input  logic              key_dir,
  output logic              q,
  output logic [LOOK-1:0]   window,
  output logic [CNT_W-1:0]  remaining,
  output logic              correct,
  output logic              wrong,
  output logic              lap,
  output logic              done
`ifdef COURSE_MISS_COUNT_EN
  ,
  output logic [7:0]        miss_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q,   state_d;
  logic [LENGTH-1:0]   sr_q,      sr_d;
  logic [CNT_W-1:0]    rem_q,     rem_d;
  logic                wrap_q,    wrap_d;
  logic                correct_q, correct_d;
  logic                wrong_q,   wrong_d;
  logic                lap_q,     lap_d;

  // A press only counts in RUN; it is judged against the box currently at the head.
  logic                step_run;
  logic                hit;
  logic                fill;
  logic                last_box;

  assign step_run = step && (state_q == ST_RUN);
  assign hit      = (key_dir == sr_q[0]);
  // In wrap mode the consumed box re-enters at the top, so after LENGTH hits the pattern is restored.
  assign fill     = wrap_q & sr_q[0];
  assign last_box = (rem_q == CNT_W'(1));

  // Next-state: load beats step; steps outside RUN are dropped silently.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    rem_d     = rem_q;
    wrap_d    = wrap_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    lap_d     = 1'b0;

    if (load) begin
      sr_d    = load_val;
      rem_d   = CNT_W'(LENGTH);
      wrap_d  = mode_wrap;
      state_d = ST_RUN;
    end else if (step_run) begin
      if (hit) begin
        sr_d      = {fill, sr_q[LENGTH-1:1]};
        correct_d = 1'b1;
        if (last_box) begin
          if (wrap_q) begin
            rem_d = CNT_W'(LENGTH);
            lap_d = 1'b1;
          end else begin
            rem_d   = '0;
            state_d = ST_DONE;
          end
        end else begin
          rem_d = rem_q - CNT_W'(1);
        end
      end else begin
        wrong_d = 1'b1;
      end
    end
  end

  // State register; reset returns to an empty, idle course.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      rem_q     <= '0;
      wrap_q    <= 1'b0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      lap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      rem_q     <= rem_d;
      wrap_q    <= wrap_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      lap_q     <= lap_d;
    end
  end

  // Course view is blanked outside RUN so display logic needs no state decode.
  assign q         = (state_q == ST_RUN) ? sr_q[0] : 1'b0;
  assign window    = (state_q == ST_RUN) ? sr_q[LOOK-1:0] : '0;
  assign remaining = rem_q;
  assign correct   = correct_q;
  assign wrong     = wrong_q;
  assign lap       = lap_q;
  assign done      = (state_q == ST_DONE);

`ifdef COURSE_MISS_COUNT_EN
  logic [7:0] miss_q, miss_d;

  // Miss counter tracks wrong presses since the last load, saturating at 255.
  always_comb begin
    miss_d = miss_q;
    if (load) begin
      miss_d = '0;
    end else if (wrong_d && (miss_q != 8'hFF)) begin
      miss_d = miss_q + 8'd1;
    end
  end

  // Miss counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_q <= '0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign miss_count = miss_q;
`endif

endmodule
